// File: rtl/uart_frame_parser_pkg.sv
// Shared constants and types for the UART frame parser.
// Sync bytes, FSM encoding and character-time arithmetic.
package uart_frame_parser_pkg;

  localparam logic [7:0] SYNC1 = 8'h55;
  localparam logic [7:0] SYNC2 = 8'hAA;
  localparam int unsigned CHAR_BITS = 10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR2,
    ST_LEN,
    ST_PAYLOAD,
    ST_CSUM,
    ST_OUT
  } state_t;

  // start + 8 data + stop bits per character
  function automatic int unsigned char_cycles(
    input int unsigned clk_hz,
    input int unsigned bps
  );
    return CHAR_BITS * (clk_hz / bps);
  endfunction

endpackage

// File: rtl/uart_frame_buf.sv
// Payload store for the frame parser.
// One synchronous write port, one asynchronous read port.
module uart_frame_buf #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 4
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);

  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/uart_frame_parser.sv
// Parses 55 AA LEN payload CSUM frames from a UART byte stream
// and replays accepted payloads over a valid/ready port.
module uart_frame_parser
  import uart_frame_parser_pkg::*;
#(
  parameter int unsigned CLK           = 200_000_000,
  parameter int unsigned BPS           = 115200,
  parameter int unsigned MAX_LEN       = 16,
  parameter int unsigned TIMEOUT_CHARS = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_done,
  output logic [7:0] out_data,
  output logic       out_valid,
  output logic       out_last,
  input  logic       out_ready,
  output logic       frame_ok,
  output logic       frame_err,
  output logic       rx_drop
);

  localparam int unsigned AW =
    (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int unsigned TO_CYC =
    TIMEOUT_CHARS * char_cycles(CLK, BPS);
  localparam logic [7:0] MAX_B = 8'(MAX_LEN);

  state_t      state, state_n;
  logic [7:0]  len, len_n;
  logic [7:0]  idx, idx_n;
  logic [7:0]  csum, csum_n;
  logic [31:0] cnt, cnt_n;
  logic        ok_n, err_n, drop_n;
  logic        we;
  logic        timed_out;
  logic        last_byte;
  logic [7:0]  rd_data;

  uart_frame_buf #(
    .DEPTH (MAX_LEN),
    .AW    (AW)
  ) u_buf (
    .clk   (clk),
    .we    (we),
    .waddr (idx[AW-1:0]),
    .wdata (rx_data),
    .raddr (idx[AW-1:0]),
    .rdata (rd_data)
  );

  assign timed_out = (cnt == TO_CYC - 1);
  assign last_byte = (idx == len - 8'd1);
  assign out_valid = (state == ST_OUT);
  assign out_last  = out_valid && last_byte;
  assign out_data  = out_valid ? rd_data : 8'h00;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      len       <= '0;
      idx       <= '0;
      csum      <= '0;
      cnt       <= '0;
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;
      rx_drop   <= 1'b0;
    end else begin
      state     <= state_n;
      len       <= len_n;
      idx       <= idx_n;
      csum      <= csum_n;
      cnt       <= cnt_n;
      frame_ok  <= ok_n;
      frame_err <= err_n;
      rx_drop   <= drop_n;
    end
  end

  always_comb begin
    state_n = state;
    len_n   = len;
    idx_n   = idx;
    csum_n  = csum;
    cnt_n   = '0;
    ok_n    = 1'b0;
    err_n   = 1'b0;
    drop_n  = 1'b0;
    we      = 1'b0;
    if (state inside {ST_HDR2, ST_LEN, ST_PAYLOAD, ST_CSUM}) begin
      cnt_n = cnt + 32'd1;
    end
    if (rx_done) cnt_n = '0;
    unique case (state)
      ST_IDLE: begin
        if (rx_done && rx_data == SYNC1) state_n = ST_HDR2;
      end
      ST_HDR2: begin
        if (rx_done) begin
          unique case (1'b1)
            rx_data == SYNC2: state_n = ST_LEN;
            rx_data == SYNC1: state_n = ST_HDR2;
            default:          state_n = ST_IDLE;
          endcase
        end else if (timed_out) begin
          state_n = ST_IDLE;
          err_n   = 1'b1;
        end
      end
      ST_LEN: begin
        if (rx_done) begin
          if (rx_data == 8'd0 || rx_data > MAX_B) begin
            state_n = ST_IDLE;
            err_n   = 1'b1;
          end else begin
            state_n = ST_PAYLOAD;
            len_n   = rx_data;
            idx_n   = '0;
            csum_n  = rx_data;
          end
        end else if (timed_out) begin
          state_n = ST_IDLE;
          err_n   = 1'b1;
        end
      end
      ST_PAYLOAD: begin
        if (rx_done) begin
          we     = 1'b1;
          csum_n = csum + rx_data;
          idx_n  = idx + 8'd1;
          if (idx + 8'd1 == len) state_n = ST_CSUM;
        end else if (timed_out) begin
          state_n = ST_IDLE;
          err_n   = 1'b1;
        end
      end
      ST_CSUM: begin
        if (rx_done) begin
          if (rx_data == csum) begin
            state_n = ST_OUT;
            ok_n    = 1'b1;
            idx_n   = '0;
          end else begin
            state_n = ST_IDLE;
            err_n   = 1'b1;
          end
        end else if (timed_out) begin
          state_n = ST_IDLE;
          err_n   = 1'b1;
        end
      end
      ST_OUT: begin
        // buffer is frozen here; stray bytes are only reported
        drop_n = rx_done;
        if (out_ready) begin
          if (last_byte) state_n = ST_IDLE;
          else           idx_n   = idx + 8'd1;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_frame_parser.sv
// Directed plus randomized frame bench for uart_frame_parser,
// checked against a frame-level model built from the frame rules.
module tb_uart_frame_parser;

  localparam int unsigned CLK_HZ = 1_152_000;
  localparam int unsigned BPS    = 115200;
  localparam int unsigned MAXL   = 16;
  localparam int unsigned TOC    = 4;
  localparam int TO_CYC = TOC * 10 * (CLK_HZ / BPS);

  typedef logic [7:0] bq_t [$];

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] rx_data = 8'h00;
  logic       rx_done = 1'b0;
  logic       out_ready = 1'b1;
  logic [7:0] out_data;
  logic       out_valid, out_last;
  logic       frame_ok, frame_err, rx_drop;

  uart_frame_parser #(
    .CLK           (CLK_HZ),
    .BPS           (BPS),
    .MAX_LEN       (MAXL),
    .TIMEOUT_CHARS (TOC)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rx_data   (rx_data),
    .rx_done   (rx_done),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_last  (out_last),
    .out_ready (out_ready),
    .frame_ok  (frame_ok),
    .frame_err (frame_err),
    .rx_drop   (rx_drop)
  );

  always #5 clk = ~clk;

  int chk = 0;
  int errs = 0;
  int cyc = 0;
  int n_ok = 0, n_err = 0, n_drop = 0;
  int err_edge = -1, rx_edge = -1;
  logic [8:0] got [$];
  logic       hold = 1'b0;
  logic [7:0] hold_data = 8'h00;
  logic       hold_last = 1'b0;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    chk++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // one clock: observe at negedge, then advance past posedge
  task automatic step();
    int s;
    @(negedge clk);
    if (rst) begin
      hold = 1'b0;
    end else begin
      if (hold) begin
        check("hold_valid", out_valid, 1);
        check("hold_data", out_data, hold_data);
        check("hold_last", out_last, hold_last);
      end
      s = frame_ok + frame_err + rx_drop;
      if (s != 0) check("pulse_excl", s, 1);
      if (frame_ok) n_ok++;
      if (frame_err) begin
        n_err++;
        err_edge = cyc;
      end
      if (rx_drop) n_drop++;
      if (out_valid && out_ready) got.push_back({out_last, out_data});
      if (rx_done) rx_edge = cyc + 1;
      hold = out_valid && !out_ready;
      hold_data = out_data;
      hold_last = out_last;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    rx_data = b;
    rx_done = 1'b1;
    step();
    rx_done = 1'b0;
    rx_data = 8'($urandom);
    repeat (gap) step();
  endtask

  task automatic drain(input int n, input bit rnd);
    int budget = 0;
    while (got.size() < n && budget < 2000) begin
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      step();
      budget++;
    end
    out_ready = 1'b1;
    repeat (3) step();
  endtask

  task automatic compare_out(input string tag, input bq_t exp);
    check({tag, "_cnt"}, got.size(), exp.size());
    foreach (exp[i]) begin
      if (i < got.size()) begin
        check({tag, "_data"}, got[i][7:0], exp[i]);
        check({tag, "_last"}, got[i][8], (i == exp.size() - 1));
      end
    end
  endtask

  task automatic run_frame(input string tag, input bq_t bytes,
                           input bq_t exp, input int eok,
                           input int eerr, input bit rnd);
    int ok0 = n_ok;
    int err0 = n_err;
    got.delete();
    out_ready = 1'b1;
    foreach (bytes[i]) send_byte(bytes[i], $urandom_range(0, 3));
    drain(exp.size(), rnd);
    compare_out(tag, exp);
    check({tag, "_ok"}, n_ok - ok0, eok);
    check({tag, "_err"}, n_err - err0, eerr);
    check({tag, "_idle"}, out_valid, 0);
  endtask

  bq_t fr, pl, none;
  int  len, sum, ok0, err0, d0, budget;
  bit  bad;
  logic [7:0] b, cs;

  initial begin
    rx_data = 8'h55;
    rx_done = 1'b1;
    repeat (3) step();
    check("rst_valid", out_valid, 0);
    check("rst_data", out_data, 0);
    check("rst_last", out_last, 0);
    check("rst_ok", frame_ok, 0);
    check("rst_err", frame_err, 0);
    check("rst_drop", rx_drop, 0);
    rx_done = 1'b0;
    rst = 1'b0;
    repeat (2) step();

    run_frame("good3", '{8'h55, 8'hAA, 8'h03, 8'h11, 8'h22, 8'h33, 8'h69},
              '{8'h11, 8'h22, 8'h33}, 1, 0, 0);
    run_frame("badsum", '{8'h55, 8'hAA, 8'h03, 8'h11, 8'h22, 8'h33, 8'h68},
              none, 0, 1, 0);
    run_frame("resync", '{8'h55, 8'h55, 8'hAA, 8'h01, 8'h7F, 8'h80},
              '{8'h7F}, 1, 0, 0);
    run_frame("badlen", '{8'h55, 8'hAA, 8'h00, 8'h55, 8'hAA, 8'h11},
              none, 0, 2, 0);
    run_frame("maxlen_ok", '{8'h55, 8'hAA, 8'h10,
              8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08,
              8'h09, 8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'h0E, 8'h0F, 8'h10,
              8'h98},
              '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08,
              8'h09, 8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'h0E, 8'h0F, 8'h10},
              1, 0, 1);

    err0 = n_err;
    fr = '{8'h55, 8'hAA, 8'h02, 8'h11};
    foreach (fr[i]) send_byte(fr[i], 1);
    budget = 0;
    while (n_err == err0 && budget < TO_CYC + 200) begin
      step();
      budget++;
    end
    check("to_err", n_err - err0, 1);
    check("to_delay", err_edge - rx_edge, TO_CYC);
    run_frame("after_to", '{8'h55, 8'hAA, 8'h02, 8'h01, 8'hFF, 8'h02},
              '{8'h01, 8'hFF}, 1, 0, 0);

    ok0 = n_ok;
    d0 = n_drop;
    got.delete();
    out_ready = 1'b0;
    fr = '{8'h55, 8'hAA, 8'h02, 8'hA1, 8'hB2, 8'h55};
    foreach (fr[i]) send_byte(fr[i], 0);
    for (int c = 0; c < 5; c++) begin
      if (c == 2) begin
        rx_data = 8'h55;
        rx_done = 1'b1;
      end
      step();
      rx_done = 1'b0;
    end
    check("stall_valid", out_valid, 1);
    check("stall_data", out_data, 8'hA1);
    check("stall_last", out_last, 0);
    check("stall_drop", n_drop - d0, 1);
    drain(2, 0);
    compare_out("stall", '{8'hA1, 8'hB2});
    check("stall_ok", n_ok - ok0, 1);

    for (int f = 0; f < 20; f++) begin
      fr.delete();
      pl.delete();
      len = $urandom_range(1, MAXL);
      sum = len;
      bad = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 1) == 1) begin
        b = 8'($urandom);
        if (b == 8'h55) b = 8'h00;
        fr.push_back(b);
      end
      fr.push_back(8'h55);
      fr.push_back(8'hAA);
      fr.push_back(8'(len));
      for (int i = 0; i < len; i++) begin
        b = 8'($urandom);
        pl.push_back(b);
        fr.push_back(b);
        sum += b;
      end
      cs = 8'(sum % 256);
      if (bad) cs = cs ^ 8'($urandom_range(1, 255));
      fr.push_back(cs);
      if (bad) run_frame("rnd", fr, none, 0, 1, 1);
      else     run_frame("rnd", fr, pl, 1, 0, 1);
    end

    err0 = n_err;
    out_ready = 1'b0;
    fr = '{8'h55, 8'hAA, 8'h01, 8'h3C, 8'h3D};
    foreach (fr[i]) send_byte(fr[i], 0);
    check("mid_out_valid", out_valid, 1);
    rst = 1'b1;
    repeat (2) step();
    check("rst_out_valid", out_valid, 0);
    check("rst_out_err", frame_err, 0);
    rst = 1'b0;
    out_ready = 1'b1;
    repeat (3) step();
    check("rst_no_err", n_err - err0, 0);
    check("rst_idle", out_valid, 0);

    $display("CHECKS %0d ERRORS %0d", chk, errs);
    $finish;
  end

endmodule
